// File: rtl/rs232_rx.sv
// 8N1 serial receiver with 16x oversampling and 3-sample majority voting.
// Received bytes are presented through a single-entry valid/ready holding register.
module rs232_rx #(
  parameter int unsigned CLK_HZ = 48_000_000,
  parameter int unsigned BAUD   = 115_200,
  parameter int unsigned DIV    = CLK_HZ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx232,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       ovr_clr
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rxs_q;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [3:0]      tcnt_q, tcnt_d;
  logic [3:0]      bidx_q, bidx_d;
  logic            s7_q, s7_d, s8_q, s8_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            tick;
  logic            vote_now;
  logic            wrap;
  logic            vote;
  logic            good_stop;
  logic [2:0]      bpos;

  assign tick     = (state_q != StIdle) && (pcnt_q == PW'(DIV - 1));
  assign vote_now = tick && (tcnt_q == 4'd9);
  assign wrap     = tick && (tcnt_q == 4'd15);
  // Third sample is taken live at the tick that ends tcnt 9.
  assign vote     = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
  assign bpos     = bidx_q[2:0] - 3'd1;

  // Prescaler, tick counter and vote samples.
  always_comb begin
    pcnt_d = pcnt_q;
    tcnt_d = tcnt_q;
    s7_d   = s7_q;
    s8_d   = s8_q;
    if (state_q == StIdle) begin
      pcnt_d = '0;
      tcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
      tcnt_d = tcnt_q + 4'd1;
      if (tcnt_q == 4'd7) s7_d = rxs_q;
      if (tcnt_q == 4'd8) s8_d = rxs_q;
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  // Frame state machine.
  always_comb begin
    state_d     = state_q;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    good_stop   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          bidx_d  = 4'd0;
        end
      end
      StStart: begin
        if (vote_now && vote) begin
          state_d = StIdle;
        end else if (wrap) begin
          state_d = StData;
          bidx_d  = 4'd1;
        end
      end
      StData: begin
        if (vote_now) shift_d[bpos] = vote;
        if (wrap) begin
          bidx_d = bidx_q + 4'd1;
          if (bidx_q == 4'd8) state_d = StStop;
        end
      end
      StStop: begin
        if (vote_now) begin
          if (vote) begin
            // Leave mid-stop so a back-to-back start edge is caught.
            good_stop = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register and overrun flag; a new overrun beats ovr_clr.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (good_stop) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= StIdle;
      pcnt_q      <= '0;
      tcnt_q      <= '0;
      bidx_q      <= '0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx232;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      tcnt_q      <= tcnt_d;
      bidx_q      <= bidx_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/rs232_rx.md
# rs232_rx

Asynchronous serial receiver for the `rx232` pin of the blaster board. It recovers 8N1 frames (LSB first) with 16x oversampling and 3-sample majority voting, and presents each received byte on a single-entry valid/ready output. It runs in the 48 MHz `clk` domain alongside `key_scan` and `blaster`. It is the receiving end of the board's RS-232 link; the `tx232` transmit path is a separate block.

## Interface
- `CLK_HZ`, 48_000_000, frequency of `clk` in Hz.
- `BAUD`, 115200, line rate in bits/s.
- `DIV`, CLK_HZ/(BAUD*16) truncated (26 at the defaults), clocks per oversample tick; must be ≥ 4.
- `clk`  in  1  system clock (48 MHz); one clock domain only.
- `reset_n`  in  1  asynchronous, active-low reset; all state clears on assertion.
- `rx232`  in  1  raw serial line; idle is high; asynchronous to `clk`.
- `rx_data`  out  8  received byte; stable while `rx_valid` is high.
- `rx_valid`  out  1  holding register contains an unconsumed byte.
- `rx_ready`  in  1  consumer accepts the byte in a cycle where `rx_valid && rx_ready`.
- `frame_err`  out  1  one-clock pulse when a stop bit samples low.
- `overrun`  out  1  sticky flag; set when a byte is lost; cleared by `ovr_clr`.
- `ovr_clr`  in  1  one-clock clear of `overrun`.

## Operation
- Input conditioning: a 2-flop synchronizer, reset to 1, produces `rxs`. Every internal decision uses `rxs`.
- Prescaler: counts 0..DIV-1 and emits `tick` when it reaches DIV-1. It is forced to 0 on start detect.
- Tick counter: `tcnt` is 4 bits, 0..15, and advances on each `tick`. Bit index `bidx` runs 0..9: 0 is the start bit, 1..8 are data bits, 9 is the stop bit.
- Majority vote: `rxs` is sampled at `tcnt` 7, 8 and 9. The bit value is the majority of those three samples and is decided at the tick that ends `tcnt` 9.
- State machine:
  - IDLE: on `rxs == 0`, go to START. Clear the prescaler, `tcnt` and `bidx`.
  - START: on the vote, a 1 is a false start and returns to IDLE with no flags. A 0 moves to DATA on the wrap of `tcnt` 15→0.
  - DATA: the vote result is shifted into the shift register at bit position `bidx-1`. After `bidx` 8 completes, go to STOP.
  - STOP: a vote of 1 means the frame is good. Load the holding register, or set overrun (see below), then go to IDLE immediately; the line is mid-stop and still high. A vote of 0 raises `frame_err` for one clock, discards the byte and goes to BREAK.
  - BREAK: wait for `rxs == 1`, then go to IDLE. This prevents a held-low line from producing a stream of framing errors.
- Holding register:
  - A good byte loads `rx_data` and sets `rx_valid` when the register is empty, or when it is being consumed in the same cycle (`rx_valid && rx_ready`).
  - Otherwise the new byte is dropped, the old byte is kept and `overrun` is set.
  - `rx_valid` clears on handshake.
- Overrun priority: if `ovr_clr` and a new overrun event occur in the same cycle, `overrun` stays 1.
- Reset values: `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, state IDLE, synchronizer = 1.
- Reset mid-frame: the partial byte is discarded. After `reset_n` releases, a line that is still low is treated as a new start bit.

## Timing
- Start detect: 2–3 clocks after the pin falls, because of the synchronizer.
- Bit decision: the vote for bit `b` resolves (16·b + 10)·DIV clocks after start detect.
- Frame latency: `rx_valid` rises 1 clock after the stop-bit vote, which is (16·9 + 10)·DIV + 1 clocks after start detect. At defaults this is 4005 clocks.
- Back-to-back frames: the next start edge is accepted from the clock after the stop vote. No extra idle time is needed.
- Consumption: `rx_valid` falls the clock after the handshake cycle, unless a new byte is loaded in that same cycle.
- Baud tolerance: defaults must tolerate a ±3% transmitter rate error.
- Pulse widths: `frame_err` is exactly 1 clock wide, and so is `tick`.

## Test plan
- Defaults, `rx_ready` = 1, a 0x55 frame at 416 clocks/bit → `rx_valid` high for 1 clock with `rx_data` = 0x55; `frame_err` = 0 and `overrun` = 0.
- Bytes 0xA3, 0x00 and 0xFF sent back-to-back with no idle, `rx_ready` = 1 → three valid pulses carrying 0xA3, 0x00, 0xFF in order.
- A 100-clock low glitch on the idle line → no `rx_valid` and no `frame_err`; state returns to IDLE.
- 0x3C with the stop bit driven low, then the line held low for 2000 clocks → exactly one `frame_err` pulse and no `rx_valid`. A following 0x81 frame is received correctly.
- `rx_ready` = 0; send 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun` = 1. Then pulse `rx_ready` → 0x11 is consumed and `rx_valid` = 0. Pulse `ovr_clr` → `overrun` = 0.
- Sender at +3%, then −3%, sends 0xC5 → received as 0xC5. Separately, assert `reset_n` low during data bit 4 of a frame → all outputs go to their reset values and no byte is delivered for that frame.
